// File: rtl/robertson_arbiter.sv
// Round-robin front end that shares one 8-bit Robertson multiplier between N_REQ requesters.
// It sequences the multiplier bus protocol and returns the assembled 16-bit product.
module robertson_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 63
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   mcand,
    input  logic [8*N_REQ-1:0]   mplier,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [15:0]          product,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 mul_enable,
    output logic [7:0]           mul_inbus,
    input  logic                 mul_done,
    input  logic [7:0]           mul_outbus
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        StIdle, StStart, StLoadM, StLoadQ, StWait, StReadQ, StResp
    } state_e;

    state_e         state_q;
    logic [IW-1:0]  rr_q;
    logic [IW-1:0]  idx_q;
    logic [7:0]     mcand_q;
    logic [7:0]     mplier_q;
    logic [7:0]     a_q;
    logic [7:0]     cnt_q;

    logic             pick_valid;
    logic [IW-1:0]    pick_idx;
    logic [IW-1:0]    rr_next;
    logic [N_REQ-1:0] pick_oh;
    logic [N_REQ-1:0] idx_oh;
    logic [7:0]       pick_mcand;
    logic [7:0]       pick_mplier;
    int unsigned      cand;

    // First requesting index at or after the round-robin pointer, wrapping modulo N_REQ.
    always_comb begin
        pick_valid  = 1'b0;
        pick_idx    = '0;
        rr_next     = '0;
        pick_oh     = '0;
        pick_mcand  = '0;
        pick_mplier = '0;
        cand        = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = (32'(rr_q) + k) % N_REQ;
            if (!pick_valid && req[IW'(cand)]) begin
                pick_valid           = 1'b1;
                pick_idx             = IW'(cand);
                rr_next              = IW'((cand + 1) % N_REQ);
                pick_oh[IW'(cand)]   = 1'b1;
                pick_mcand           = mcand[8*cand +: 8];
                pick_mplier          = mplier[8*cand +: 8];
            end
        end
    end

    always_comb begin
        idx_oh        = '0;
        idx_oh[idx_q] = 1'b1;
    end

    // Outputs are registered, so each one is loaded on the edge entering the state that owns it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rr_q       <= '0;
            idx_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            a_q        <= '0;
            cnt_q      <= '0;
            gnt        <= '0;
            rsp_valid  <= '0;
            product    <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
            mul_enable <= 1'b0;
            mul_inbus  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        mcand_q    <= pick_mcand;
                        mplier_q   <= pick_mplier;
                        idx_q      <= pick_idx;
                        rr_q       <= rr_next;
                        gnt        <= pick_oh;
                        mul_enable <= 1'b1;
                        mul_inbus  <= '0;
                        busy       <= 1'b1;
                        state_q    <= StStart;
                    end
                end
                StStart: begin
                    gnt        <= '0;
                    mul_enable <= 1'b0;
                    mul_inbus  <= mcand_q;
                    state_q    <= StLoadM;
                end
                StLoadM: begin
                    mul_inbus <= mplier_q;
                    state_q   <= StLoadQ;
                end
                StLoadQ: begin
                    cnt_q     <= '0;
                    mul_inbus <= '0;
                    state_q   <= StWait;
                end
                StWait: begin
                    if (mul_done) begin
                        a_q     <= mul_outbus;
                        state_q <= StReadQ;
                    end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                        rsp_valid <= idx_oh;
                        product   <= '0;
                        rsp_err   <= 1'b1;
                        state_q   <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StReadQ: begin
                    rsp_valid <= idx_oh;
                    product   <= {a_q, mul_outbus};
                    rsp_err   <= 1'b0;
                    state_q   <= StResp;
                end
                StResp: begin
                    rsp_valid <= '0;
                    busy      <= 1'b0;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
